timex_paging_ctrl: RTL

//  Clocked, parametrised paging/decode controller for the Timex FDD interface. Sits between the
//  ZX Spectrum bus and the interface ROM/RAM/LS273/LS244. Samples the bus into a system clock and

---
 rtl/timex_if_pkg.sv | 30 +++
 rtl/timex_bus_sync.sv | 44 ++++
 rtl/timex_paging_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/timex_if_pkg.sv
// Shared types, control-register layout and default decode constants for the
// Timex FDD paging controller.
package timex_if_pkg;

    typedef enum logic {
        PG_OUT = 1'b0,
        PG_IN  = 1'b1
    } page_state_t;

    localparam int CTRL_TRAP_EN = 0;
    localparam int CTRL_FORCE   = 1;
    localparam int CTRL_RAM_WP  = 2;

    localparam logic [7:0] CTRL_RESET   = 8'h01;
    localparam logic [7:0] CTRL_WR_MASK = 8'h07;

    localparam logic [31:0] DEF_TRAP_ADDRS = 32'h0008_0000;
    localparam logic [15:0] DEF_PO_ADDR    = 16'h0604;
    localparam logic [15:0] DEF_PO_MASK    = 16'hFFFC;
    localparam logic [7:0]  DEF_DATA_PORT  = 8'h3F;
    localparam logic [7:0]  DEF_CTRL_PORT  = 8'h3E;
    localparam logic [7:0]  DEF_IO_MASK    = 8'h3F;

    function automatic logic io_match(input logic [7:0] addr,
                                      input logic [7:0] port,
                                      input logic [7:0] mask);
        return ((addr & mask) == (port & mask));
    endfunction

endpackage

// File: rtl/timex_bus_sync.sv
// Multi-stage synchroniser for asynchronous active-low bus strobes, with
// rise/fall detection on the final stage.
module timex_bus_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] rise
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;
    logic [WIDTH-1:0]             last_q;
    logic [WIDTH-1:0]             last_d;

    // Shift chain; last_q holds the previous final-stage value for edge detection.
    always_comb begin
        stage_d[0] = async_in;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        last_d = stage_q[STAGES-1];
    end

    // Strobes idle high, so reset to all ones: no spurious edge leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '1;
            last_q  <= '1;
        end else begin
            stage_q <= stage_d;
            last_q  <= last_d;
        end
    end

    assign sync_out = stage_q[STAGES-1];
    assign fall     = last_q & ~stage_q[STAGES-1];
    assign rise     = ~last_q & stage_q[STAGES-1];

endmodule

// File: rtl/timex_paging_ctrl.sv
// Timex FDD paging/decode controller: synchronised bus sampling, trap/page-out
// FSM, CPU control register and combinational chip-select/I-O decode.
module timex_paging_ctrl
    import timex_if_pkg::*;
#(
    parameter int                      SYNC_STAGES = 2,
    parameter int                      NUM_TRAPS   = 2,
    parameter logic [16*NUM_TRAPS-1:0] TRAP_ADDRS  = DEF_TRAP_ADDRS,
    parameter logic [15:0]             PO_ADDR     = DEF_PO_ADDR,
    parameter logic [15:0]             PO_MASK     = DEF_PO_MASK,
    parameter logic [7:0]              DATA_PORT   = DEF_DATA_PORT,
    parameter logic [7:0]              CTRL_PORT   = DEF_CTRL_PORT,
    parameter logic [7:0]              IO_MASK     = DEF_IO_MASK
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        n_mreq,
    input  logic        n_iorq,
    input  logic        n_rd,
    input  logic        n_wr,
    input  logic        n_m1,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        n_zx_romcs,
    output logic        n_rom_cs,
    output logic        n_ram_cs,
    output logic        ls273_stb,
    output logic        n_ls244,
    output logic        paged,
    output logic        trap_pulse
);

    logic [2:0] async_s;
    logic [2:0] sync_s;
    logic [2:0] fall_s;
    logic [2:0] rise_s;

    assign async_s = {n_wr, n_iorq, n_mreq};

    timex_bus_sync #(
        .STAGES(SYNC_STAGES),
        .WIDTH (3)
    ) u_bus_sync (
        .clk     (clk),
        .rst     (rst),
        .async_in(async_s),
        .sync_out(sync_s),
        .fall    (fall_s),
        .rise    (rise_s)
    );

    logic mreq_fall_s;
    logic mreq_rise_s;
    logic iowr_n_s;
    logic iowr_fall_s;
    logic unused_sync_s;

    assign mreq_fall_s   = fall_s[0];
    assign mreq_rise_s   = rise_s[0];
    assign iowr_n_s      = sync_s[1] | sync_s[2];
    assign unused_sync_s = ^{sync_s[0], fall_s[2:1], rise_s[2:1]};

    page_state_t state_q, state_d;
    logic [15:0] cyc_addr_q, cyc_addr_d;
    logic        cyc_m1_q, cyc_m1_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic        iowr_prev_q, iowr_prev_d;
    logic        trap_pulse_q, trap_pulse_d;

    assign iowr_fall_s = iowr_prev_q & ~iowr_n_s;

    logic ctrl_match_s;
    logic data_match_s;

    assign ctrl_match_s = io_match(a[7:0], CTRL_PORT, IO_MASK);
    assign data_match_s = io_match(a[7:0], DATA_PORT, IO_MASK);

    // Address and M1 are captured at the start of the cycle; the FSM acts on them at its end.
    always_comb begin
        cyc_addr_d  = cyc_addr_q;
        cyc_m1_d    = cyc_m1_q;
        iowr_prev_d = iowr_n_s;
        if (mreq_fall_s) begin
            cyc_addr_d = a;
            cyc_m1_d   = n_m1;
        end else begin
            cyc_addr_d = cyc_addr_q;
            cyc_m1_d   = cyc_m1_q;
        end
    end

    // Control register write from the CPU on the synchronised I/O write edge.
    always_comb begin
        ctrl_d = ctrl_q;
        if (iowr_fall_s && ctrl_match_s) begin
            ctrl_d = d_in & CTRL_WR_MASK;
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    logic [NUM_TRAPS-1:0] trap_hit_vec_s;

    for (genvar i = 0; i < NUM_TRAPS; i++) begin : g_trap
        assign trap_hit_vec_s[i] = (cyc_addr_q == TRAP_ADDRS[16*i +: 16]);
    end

    logic po_hit_s;
    logic m1_trap_s;
    logic m1_po_s;
    logic force_s;

    assign po_hit_s  = ((cyc_addr_q & PO_MASK) == (PO_ADDR & PO_MASK));
    assign m1_trap_s = mreq_rise_s & ~cyc_m1_q & ctrl_q[CTRL_TRAP_EN] & (|trap_hit_vec_s);
    assign m1_po_s   = mreq_rise_s & ~cyc_m1_q & po_hit_s;
    assign force_s   = ctrl_q[CTRL_FORCE];

    // Page FSM: each state only looks at its own exit condition, which gives the required priority.
    always_comb begin
        state_d      = state_q;
        trap_pulse_d = 1'b0;
        case (state_q)
            PG_OUT: begin
                if (force_s || m1_trap_s) begin
                    state_d      = PG_IN;
                    trap_pulse_d = 1'b1;
                end else begin
                    state_d = PG_OUT;
                end
            end
            PG_IN: begin
                if (!force_s && m1_po_s) begin
                    state_d = PG_OUT;
                end else begin
                    state_d = PG_IN;
                end
            end
            default: begin
                state_d = PG_OUT;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PG_OUT;
            cyc_addr_q   <= 16'h0000;
            cyc_m1_q     <= 1'b1;
            ctrl_q       <= CTRL_RESET;
            iowr_prev_q  <= 1'b1;
            trap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_addr_q   <= cyc_addr_d;
            cyc_m1_q     <= cyc_m1_d;
            ctrl_q       <= ctrl_d;
            iowr_prev_q  <= iowr_prev_d;
            trap_pulse_q <= trap_pulse_d;
        end
    end

    logic mem_act_s;
    logic io_act_s;
    logic ram_wr_block_s;

    // Decode uses the raw bus so selects track the current access with no sync delay.
    assign mem_act_s      = ~rst & ~n_mreq & paged;
    assign io_act_s       = ~rst & ~n_iorq;
    assign ram_wr_block_s = ctrl_q[CTRL_RAM_WP] & ~n_wr;

    assign paged      = (state_q == PG_IN);
    assign trap_pulse = trap_pulse_q;
    assign d_out      = ctrl_q;
    assign n_zx_romcs = ~paged;
    assign n_rom_cs   = ~(mem_act_s & (a[15:13] == 3'b000));
    assign n_ram_cs   = ~(mem_act_s & (a[15:13] == 3'b001) & ~ram_wr_block_s);
    assign ls273_stb  = io_act_s & ~n_wr & data_match_s;
    assign n_ls244    = ~(io_act_s & ~n_rd & data_match_s);
    assign d_oe       = io_act_s & ~n_rd & ctrl_match_s;

endmodule
